alu_instr_tx: RTL
=================

ALU_INSTR_TX -- requirements
Module: alu_instr_tx

Interface
REQ-001 SHALL provide parameter STROBE_CYCLES, default 2: clk cycles load_strobe is held high per bit (legal 1-15).
REQ-002 SHALL provide parameter GAP_CYCLES, default 2: clk cycles load_strobe is held low after each strobe (legal 1-15).
REQ-003 SHALL provide parameter ACK_TIMEOUT, default 15: maximum clk cycles spent waiting for ack_in after the last bit (legal 1-255).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset_instr  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to send instr_in; sampled only in IDLE.
REQ-007 instr_in  input  4  instruction to serialize.
REQ-008 ack_in  input  1  receiver done indication; sampled only in WAIT_ACK.
REQ-009 bit_out  output  1  serial data bit, LSB first.
REQ-010 load_strobe  output  1  load strobe to receiver; receiver captures bit_out on its rising edge.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse: frame sent and acknowledged.
REQ-013 error  output  1  one-cycle pulse: acknowledge timeout.

Function
REQ-014 States SHALL be IDLE, SETUP, STROBE, GAP, WAIT_ACK; done/error SHALL be registered pulses issued on the transition from WAIT_ACK to IDLE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture instr_in into a 4-bit shift register, clear bit index to 0, and enter SETUP.
REQ-016 start SHALL be ignored in every state other than IDLE; instr_in changes after capture SHALL NOT affect the frame.
REQ-017 SETUP SHALL last exactly 1 cycle with bit_out = shift[0] and load_strobe = 0, then enter STROBE.
REQ-018 STROBE SHALL last exactly STROBE_CYCLES cycles with load_strobe = 1, then enter GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles with load_strobe = 0; bit_out SHALL remain stable from SETUP through the end of GAP.
REQ-020 At the end of GAP, if bit index < 3 the block SHALL shift right by one, increment bit index, and enter SETUP; if bit index = 3 it SHALL enter WAIT_ACK.
REQ-021 Frame length from the capture edge to WAIT_ACK entry SHALL be 4 x (1 + STROBE_CYCLES + GAP_CYCLES) cycles (20 at defaults).
REQ-022 load_strobe SHALL be driven directly from a register (glitch-free), and SHALL produce exactly 4 rising edges per frame.
REQ-023 In WAIT_ACK a timeout counter SHALL increment each cycle; ack_in = 1 SHALL end the frame with done = 1 for one cycle and return to IDLE.
REQ-024 If ack_in is not seen within ACK_TIMEOUT cycles of WAIT_ACK entry, the block SHALL pulse error for one cycle and return to IDLE.
REQ-025 If ack_in = 1 on the same edge the timeout expires, ack SHALL win (done, no error).
REQ-026 ack_in SHALL be ignored in SETUP, STROBE and GAP.
REQ-027 done and error SHALL never be high in the same cycle; busy SHALL be low in the cycle done/error is high.
REQ-028 start=1 in the cycle done/error is high SHALL be accepted (back-to-back frames, no dead cycle beyond IDLE).

Reset
REQ-029 reset_instr = 1 SHALL immediately force state IDLE, shift register 0, bit index 0, timeout counter 0, and bit_out, load_strobe, busy, done, error all 0.
REQ-030 Reset asserted mid-frame (including mid-strobe) SHALL drop load_strobe asynchronously and abandon the frame; no done or error SHALL follow.
REQ-031 After reset release, the first edge SHALL behave as IDLE (start accepted on that edge).

Verification
REQ-032 Defaults, start with instr_in=4'b1011, ack_in pulsed 3 cycles after WAIT_ACK entry -> bit_out sequence 1,1,0,1 at the 4 strobe rising edges, strobe high 2 cycles/low 2 cycles, WAIT_ACK at cycle 20, done pulse at cycle 23.
REQ-033 Defaults, instr_in=4'b0110, ack_in held 0 -> 4 strobes with bits 0,1,1,0, error pulse exactly 15 cycles after WAIT_ACK entry, busy low thereafter.
REQ-034 Start 4'b1001, toggle start and instr_in to 4'b0000 during the frame -> transmitted bits remain 1,0,0,1; no second frame begins.
REQ-035 Assert reset_instr during the second strobe -> load_strobe low the same cycle, busy 0, no done/error; subsequent start 4'b0101 sends 1,0,1,0 cleanly.
REQ-036 start held high continuously with ack_in tied 1 -> done pulses every 22 cycles (20 frame + 1 WAIT_ACK + 1 IDLE edge), frames contiguous.
REQ-037 STROBE_CYCLES=1, GAP_CYCLES=1 build -> 12-cycle frame, each strobe exactly 1 cycle high, ack and timeout coinciding gives done only.

Source files
------------

// File: rtl/alu_instr_tx.sv
// alu_instr_tx
//   Serializes a 4-bit ALU instruction to a receiver, LSB first. Each bit is
//   presented on bit_out for one SETUP cycle. load_strobe is then raised for
//   STROBE_CYCLES and dropped for GAP_CYCLES. After the fourth bit the block
//   waits up to ACK_TIMEOUT cycles for ack_in. It then returns to IDLE with a
//   one-cycle done pulse (acknowledged) or error pulse (timed out).
//
//   Ports
//     clk          clock, rising edge
//     reset_instr  asynchronous, active-high reset
//     start        frame request, sampled only in IDLE
//     instr_in     instruction captured on the accepting edge
//     ack_in       receiver acknowledge, sampled only in WAIT_ACK
//     bit_out      serial data bit (registered)
//     load_strobe  receiver capture strobe (registered, glitch-free)
//     busy         high in every state except IDLE
//     done         one-cycle pulse, frame acknowledged
//     error        one-cycle pulse, acknowledge timeout
module alu_instr_tx #(
    parameter int STROBE_CYCLES = 2,   // 1..15
    parameter int GAP_CYCLES    = 2,   // 1..15
    parameter int ACK_TIMEOUT   = 15   // 1..255
) (
    input  logic       clk,
    input  logic       reset_instr,
    input  logic       start,
    input  logic [3:0] instr_in,
    input  logic       ack_in,
    output logic       bit_out,
    output logic       load_strobe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        GAP      = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    // Terminal counts. Each phase counter starts at 0 on phase entry, so the
    // phase lasts exactly N cycles when it leaves on count N-1.
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LAST    = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [3:0] shift_q;
    logic [1:0] bit_idx;
    logic [3:0] phase_cnt;
    logic [7:0] tmo_cnt;

    // Every output is a plain register. The strobe therefore cannot glitch,
    // and reset clears it asynchronously.
    always_ff @(posedge clk or posedge reset_instr) begin
        if (reset_instr) begin
            state       <= IDLE;
            shift_q     <= 4'd0;
            bit_idx     <= 2'd0;
            phase_cnt   <= 4'd0;
            tmo_cnt     <= 8'd0;
            bit_out     <= 1'b0;
            load_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q   <= instr_in;
                        bit_idx   <= 2'd0;
                        phase_cnt <= 4'd0;
                        bit_out   <= instr_in[0];
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    load_strobe <= 1'b1;
                    phase_cnt   <= 4'd0;
                    state       <= STROBE;
                end

                STROBE: begin
                    if (phase_cnt == STROBE_LAST) begin
                        load_strobe <= 1'b0;
                        phase_cnt   <= 4'd0;
                        state       <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end

                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= 4'd0;
                        if (bit_idx != 2'd3) begin
                            // The next bit goes onto the line together with
                            // the SETUP entry. It then holds through that
                            // bit's GAP.
                            shift_q <= {1'b0, shift_q[3:1]};
                            bit_out <= shift_q[1];
                            bit_idx <= bit_idx + 2'd1;
                            state   <= SETUP;
                        end else begin
                            tmo_cnt <= 8'd0;
                            state   <= WAIT_ACK;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end

                WAIT_ACK: begin
                    // ack is tested before the timeout, so an ack that arrives
                    // on the expiring edge still counts as done.
                    if (ack_in) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        bit_out <= 1'b0;
                        state   <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        bit_out <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                default: begin
                    load_strobe <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
